// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between pipeline and multi-cycle writeback
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [ADDRESS_WIDTH-1:0]      req0_rd,
  input  logic [DATA_WIDTH-1:0]         req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ADDRESS_WIDTH-1:0]      req1_rd,
  input  logic [DATA_WIDTH-1:0]         req1_data,
  output logic                          req1_ready,
  input  logic                          iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]      iss_rd,
  output logic                          iss_ready,
  output logic [2**ADDRESS_WIDTH-1:0]   pend,
  output logic [ADDRESS_WIDTH-1:0]      A3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic                          WE3
);
  localparam int NREG = 2**ADDRESS_WIDTH;
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic {NORMAL, STARVE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic [NREG-1:0] pend_nxt;
  logic blocked, iss_xfer;
  assign iss_ready = !pend[iss_rd] || iss_rd == '0;
  assign iss_xfer = iss_valid && iss_ready && iss_rd != '0;
  assign blocked = req1_valid && !req1_ready;
  always_comb begin
    req0_ready = !rst && state == NORMAL && req0_valid;
    req1_ready = !rst && req1_valid && (state == STARVE || !req0_valid);
    wait_nxt = state == STARVE ? (req1_ready ? '0 : wait_cnt) : (blocked ? wait_cnt + 1'b1 : '0);
    state_nxt = state == STARVE ? (req1_ready ? NORMAL : STARVE)
              : (blocked && wait_cnt + 1'b1 == CW'(MAX_WAIT) ? STARVE : NORMAL);
    pend_nxt = pend;
    if (req1_ready) pend_nxt[req1_rd] = 1'b0;
    // set after clear so a same-cycle issue to the same register keeps it pending
    if (iss_xfer) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      wait_cnt <= '0;
      pend <= '0;
      A3 <= '0;
      WD3 <= '0;
      WE3 <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      pend <= pend_nxt;
      WE3 <= req0_ready ? req0_rd != '0 : req1_ready && req1_rd != '0;
      if (req0_ready || req1_ready) begin
        A3 <= req0_ready ? req0_rd : req1_rd;
        WD3 <= req0_ready ? req0_data : req1_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int MW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0] req0_rd = '0, req1_rd = '0, iss_rd = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, iss_ready, WE3;
  logic [31:0] pend, WD3;
  logic [4:0] A3;
  typedef struct {int due; logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  wr_t w_mon;
  logic [31:0] mpend = '0;
  int blocked = 0, cyc = 0, n_cmp = 0, n_err = 0;
  logic started = 1'b0, g0 = 1'b0, g1 = 1'b0;
  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .pend(pend), .A3(A3), .WD3(WD3), .WE3(WE3)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // One clock: drive inputs, check readiness against the reference, then advance the reference.
  task automatic cycle(input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ia);
    logic e0, e1, ei;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_rd = a0; req0_data = d0;
    req1_valid = v1; req1_rd = a1; req1_data = d1; iss_valid = iv; iss_rd = ia;
    e0 = !r && v0 && !(v1 && blocked >= MW);
    e1 = !r && v1 && (!v0 || blocked >= MW);
    ei = !mpend[ia] || ia == 0;
    #1;
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("iss_ready", 64'(iss_ready), 64'(ei));
    @(posedge clk);
    cyc++;
    if (r) begin
      blocked = 0;
      mpend = '0;
    end else begin
      blocked = (v1 && !e1) ? blocked + 1 : 0;
      if (e1) mpend[a1] = 1'b0;
      if (iv && ei && ia != 0) mpend[ia] = 1'b1;
      if (e0 && a0 != 0) q.push_back('{cyc, a0, d0});
      if (e1 && a1 != 0) q.push_back('{cyc, a1, d1});
    end
    g0 = e0;
    g1 = e1;
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) if (started) begin
    chk("pend", 64'(pend), 64'(mpend));
    if (WE3) begin
      if (q.size() == 0) chk("spurious_WE3", 64'(WE3), 64'(0));
      else begin
        w_mon = q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(w_mon.due));
        chk("A3", 64'(A3), 64'(w_mon.a));
        chk("WD3", 64'(WD3), 64'(w_mon.d));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      w_mon = q.pop_front();
      chk("missing_WE3", 64'(WE3), 64'(1));
    end
  end
  initial begin
    logic v0, v1;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_A3", 64'(A3), 0);
    chk("rst_WD3", 64'(WD3), 0);
    chk("rst_WE3", 64'(WE3), 0);
    chk("rst_pend", 64'(pend), 0);
    started = 1'b1;
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(); idle();
    cycle(0, 1, 3, 32'h0000AAAA, 1, 7, 32'h0000BBBB, 0, 0);
    cycle(0, 0, 0, 0, 1, 7, 32'h0000BBBB, 0, 0);
    idle();
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 5'(i + 10), 32'(i), v1, 2, 32'h22, 0, 0);
      if (g1) v1 = 1'b0;
    end
    idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cycle(0, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    idle();
    cycle(0, 0, 0, 0, 1, 9, 32'h98, 1, 9);
    idle();
    cycle(0, 0, 0, 0, 1, 9, 32'h97, 0, 0);
    idle();
    cycle(0, 1, 0, 32'h1234, 0, 0, 0, 1, 0);
    idle(); idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 4);
    for (int i = 0; i < MW; i++) cycle(0, 1, 5'(i + 1), 32'(i + 100), 1, 4, 32'h44, 0, 0);
    cycle(1, 1, 1, 32'h55, 1, 4, 32'h44, 0, 0);
    #2;
    chk("rst6_WE3", 64'(WE3), 0);
    chk("rst6_A3", 64'(A3), 0);
    chk("rst6_pend", 64'(pend), 0);
    cycle(0, 1, 6, 32'h66, 1, 4, 32'h44, 0, 0);
    cycle(0, 0, 0, 0, 1, 4, 32'h44, 0, 0);
    idle();
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 2000; i++) begin
      logic iv;
      logic [4:0] ia;
      if (!(v0 && !g0)) begin
        v0 = $urandom_range(0, 99) < 60;
        a0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!(v1 && !g1)) begin
        v1 = $urandom_range(0, 99) < 40;
        a1 = 5'($urandom_range(0, 7));
        d1 = $urandom;
      end
      iv = $urandom_range(0, 99) < 30;
      ia = 5'($urandom_range(0, 7));
      cycle(0, v0, a0, d0, v1, a1, d1, iv, ia);
    end
    idle(); idle(); idle();
    chk("drain", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
